// File: rtl/muldiv_unit.sv
// Iterative MIPS-style HI/LO multiply/divide unit: one shift-add or restoring
// shift-subtract step per cycle on operand magnitudes, sign fix-up at the end.
module muldiv_unit #(
    parameter int k = 32
) (
    input  logic         Clk,
    input  logic         Rst_n,
    input  logic         Run,
    input  logic [k-1:0] busA,
    input  logic [k-1:0] busB,
    input  logic [1:0]   Op,
    input  logic         Start,
    input  logic         MtHi,
    input  logic         MtLo,
    output logic         Busy,
    output logic         Done,
    output logic [k-1:0] Hi,
    output logic [k-1:0] Lo,
    output logic         DivZero
);

    localparam int CW = $clog2(k);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic [k-1:0]  acc_hi, acc_lo, opnd;
    logic          is_div, neg_lo, neg_hi, b_zero, done_q;

    logic          sign_a, sign_b;
    logic [k-1:0]  mag_a, mag_b;
    logic [k:0]    mul_sum, div_tmp, div_diff;
    logic          div_ok;
    logic [2*k-1:0] prod, prod_fix;
    logic [k-1:0]  quo_fix, rem_fix, res_hi, res_lo;

    // Op[0] selects the signed variants; Op[1] selects divide.
    assign sign_a = Op[0] & busA[k-1];
    assign sign_b = Op[0] & busB[k-1];
    assign mag_a  = sign_a ? -busA : busA;
    assign mag_b  = sign_b ? -busB : busB;

    assign Done = done_q & Run;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (Start) state_nxt = CALC;
            CALC:    if (cnt == CW'(k-1)) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n)
            state <= IDLE;
        else if (Run)
            state <= state_nxt;
    end

    // acc_hi:acc_lo is the partial product (multiply) or remainder:quotient (divide).
    always_comb begin
        mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
        div_tmp  = {acc_hi, acc_lo[k-1]};
        div_diff = div_tmp - {1'b0, opnd};
        div_ok   = ~div_diff[k];
    end

    // Divide-by-zero leaves the dividend magnitude in the remainder, so the
    // usual remainder sign fix restores busA; only the quotient is forced.
    always_comb begin
        prod     = {acc_hi, acc_lo};
        prod_fix = neg_lo ? -prod : prod;
        quo_fix  = b_zero ? '1 : (neg_lo ? -acc_lo : acc_lo);
        rem_fix  = neg_hi ? -acc_hi : acc_hi;
        res_hi   = is_div ? rem_fix : prod_fix[2*k-1:k];
        res_lo   = is_div ? quo_fix : prod_fix[k-1:0];
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            cnt     <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            opnd    <= '0;
            is_div  <= 1'b0;
            neg_lo  <= 1'b0;
            neg_hi  <= 1'b0;
            b_zero  <= 1'b0;
            done_q  <= 1'b0;
            Busy    <= 1'b0;
            Hi      <= '0;
            Lo      <= '0;
            DivZero <= 1'b0;
        end else begin
            done_q <= Run && (state == FIX);
            if (Run) begin
                case (state)
                    IDLE: begin
                        if (Start) begin
                            is_div  <= Op[1];
                            neg_lo  <= sign_a ^ sign_b;
                            neg_hi  <= sign_a;
                            b_zero  <= Op[1] && (busB == '0);
                            opnd    <= Op[1] ? mag_b : mag_a;
                            acc_hi  <= '0;
                            acc_lo  <= Op[1] ? mag_a : mag_b;
                            cnt     <= '0;
                            Busy    <= 1'b1;
                            DivZero <= 1'b0;
                        end else begin
                            if (MtHi) Hi <= busA;
                            if (MtLo) Lo <= busA;
                        end
                    end
                    CALC: begin
                        cnt <= cnt + 1'b1;
                        if (is_div) begin
                            acc_hi <= div_ok ? div_diff[k-1:0] : div_tmp[k-1:0];
                            acc_lo <= {acc_lo[k-2:0], div_ok};
                        end else begin
                            {acc_hi, acc_lo} <= {mul_sum, acc_lo[k-1:1]};
                        end
                    end
                    FIX: begin
                        Hi      <= res_hi;
                        Lo      <= res_lo;
                        Busy    <= 1'b0;
                        DivZero <= b_zero;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter: k, 32, operand width in bits; all values below are for k=32.
REQ-002 SHALL have port: Clk  input  1  single clock; all state updates on posedge Clk.
REQ-003 SHALL have port: Rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: Run  input  1  global enable; 0 freezes all state.
REQ-005 SHALL have port: busA  input  k  operand A from register-file read port A (dividend / multiplicand / MTHI-MTLO source).
REQ-006 SHALL have port: busB  input  k  operand B from register-file read port B (divisor / multiplier).
REQ-007 SHALL have port: Op  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-008 SHALL have port: Start  input  1  request to begin Op on busA/busB.
REQ-009 SHALL have ports: MtHi, MtLo  input  1 each  write busA into Hi / Lo.
REQ-010 SHALL have port: Busy  output  1  operation in progress.
REQ-011 SHALL have port: Done  output  1  one-cycle completion pulse.
REQ-012 SHALL have ports: Hi, Lo  output  k each  HI/LO architectural registers.
REQ-013 SHALL have port: DivZero  output  1  last divide had busB=0.

Function
REQ-014 SHALL implement FSM states IDLE, CALC, FIX; a 5-bit iteration counter counts CALC cycles.
REQ-015 SHALL, in IDLE with Run=1 and Start=1, latch Op, operand magnitudes (signed ops), and result signs, clear DivZero, set Busy=1, and go to CALC at the same edge (edge E0).
REQ-016 SHALL perform one shift-add (multiply) or one restoring shift-subtract (divide) step per CALC cycle, 32 steps total (edges E1..E32), then go to FIX.
REQ-017 SHALL, at edge E33 (FIX->IDLE), apply sign correction, write Hi/Lo, clear Busy, and drive Done=1 for exactly the following cycle.
REQ-018 SHALL produce: multiply Hi:Lo = 64-bit product, signed for MULT, unsigned for MULTU.
REQ-019 SHALL produce: divide Lo = quotient truncated toward zero, Hi = remainder with the dividend's sign (DIV); unsigned for DIVU.
REQ-020 SHALL for DIV 0x80000000 / 0xFFFFFFFF give Lo=0x80000000, Hi=0x00000000, no flag.
REQ-021 SHALL for divide with busB=0 run the full 34-cycle sequence, then give Lo=0xFFFFFFFF, Hi=busA as latched at E0, and DivZero=1 with Done; DivZero holds until the next accepted Start or reset.
REQ-022 SHALL ignore Start, MtHi, and MtLo while Busy=1; latched operands are unaffected by busA/busB changes after E0.
REQ-023 SHALL, in IDLE with Start=0, write busA to Hi if MtHi=1 and to Lo if MtLo=1 (both if both); when Start=1, ignore MtHi/MtLo.
REQ-024 SHALL, when Run=0, hold state, counter, Hi, Lo, Busy, DivZero, and ignore Start/MtHi/MtLo; Done SHALL be 0 while Run=0, and a pending completion fires on the first Run=1 FIX edge.
REQ-025 SHALL keep Hi/Lo outputs stable (previous values) throughout CALC/FIX until E33.

Reset
REQ-026 SHALL, on posedge Clk with Rst_n=0, force state IDLE, counter 0, Hi=0, Lo=0, Busy=0, Done=0, DivZero=0; Rst_n overrides Run and all other inputs.
REQ-027 SHALL, on reset during CALC/FIX, abort the operation with no Hi/Lo update and no Done pulse.

Verification
REQ-028 SHALL pass: MULTU 0xFFFFFFFF x 0xFFFFFFFF, Start at E0 -> Busy 1 after E0..E33, Done 1 cycle after E33, Hi=0xFFFFFFFE, Lo=0x00000001.
REQ-029 SHALL pass: MULT 0xFFFFFFFD x 0x00000005 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFF1; DIVU 100/7 -> Lo=0x0000000E, Hi=0x00000002.
REQ-030 SHALL pass: DIV 0xFFFFFFF9 / 0x00000002 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> Lo=0x80000000, Hi=0.
REQ-031 SHALL pass: DIVU 5/0 -> Lo=0xFFFFFFFF, Hi=0x00000005, DivZero=1 until next Start.
REQ-032 SHALL pass: Run=0 for 10 cycles mid-CALC, plus Start/MtHi pulses while Busy -> Done delayed exactly 10 cycles, result identical, Hi/Lo not written by MtHi.
REQ-033 SHALL pass: Rst_n=0 at 10th CALC cycle -> next cycle Busy=0, Hi=Lo=0, no Done; then MtHi with busA=0x12345678 in IDLE -> Hi=0x12345678 next cycle.
